// File: rtl/fft_cap_pkg.sv
// rtl/fft_cap_pkg.sv - shared types and helpers for the FFT frame capture buffer
//
// Contents:
//   cap_state_t  capture FSM states (IDLE, CAPTURE, HANDOFF)
//   cap_bin_t    {real, img} bin word at the default sample width
//   cap_mag()    |re| + |im| on sign-extended operands, exact for the most negative sample
package fft_cap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        HANDOFF
    } cap_state_t;

    localparam int CAP_DATA_W = 24;

    // Wide enough for any sample width up to 64 bits; callers sign-extend into it
    // and keep only the low DATA_W+1 bits of the result.
    localparam int MAG_CALC_W = 64;

    typedef struct packed {
        logic signed [CAP_DATA_W-1:0] re;
        logic signed [CAP_DATA_W-1:0] im;
    } cap_bin_t;

    function automatic logic [MAG_CALC_W:0] cap_mag(
        input logic signed [MAG_CALC_W-1:0] re,
        input logic signed [MAG_CALC_W-1:0] im
    );
        logic [MAG_CALC_W-1:0] abs_re;
        logic [MAG_CALC_W-1:0] abs_im;
        abs_re = re[MAG_CALC_W-1] ? MAG_CALC_W'(-re) : MAG_CALC_W'(re);
        abs_im = im[MAG_CALC_W-1] ? MAG_CALC_W'(-im) : MAG_CALC_W'(im);
        return {1'b0, abs_re} + {1'b0, abs_im};
    endfunction

endpackage

// File: rtl/fft_cap_bank_ram.sv
// rtl/fft_cap_bank_ram.sv - one capture bank: simple dual-port RAM with registered read
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (read register only)
//   we, waddr, wdata    write port
//   re, raddr, rdata    read port; rdata updates the cycle after re and holds otherwise
module fft_cap_bank_ram #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_frame_capture.sv
// rtl/fft_frame_capture.sv - ping-pong FFT frame capture buffer for processor readout
//
// Optional feature macro: FFT_CAP_PEAK_EN (adds peak_bin/peak_mag magnitude tracking).
//
// Ports:
//   clk_clk, reset_reset_n               clock, asynchronous active-low reset
//   fft_start/valid/real/img/cnt         bin stream from the FFT core
//   rd_addr, rd_en, rd_data, rd_valid    processor read of the ready bank, 1-cycle latency
//   frame_ready, frame_ack               ready bank handshake
//   seq_err                              sticky bin-index mismatch flag
//   ovf_cnt                              saturating count of dropped frames
//   peak_bin, peak_mag                   largest |re|+|im| bin of the ready frame (macro only)
module fft_frame_capture
    import fft_cap_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int N_BINS = 1024,
    parameter int OVF_W  = 8,
    localparam int CNT_W = $clog2(N_BINS)
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic                     fft_start,
    input  logic                     fft_valid,
    input  logic signed [DATA_W-1:0] fft_real,
    input  logic signed [DATA_W-1:0] fft_img,
    input  logic [CNT_W-1:0]         fft_cnt,
    input  logic [CNT_W-1:0]         rd_addr,
    input  logic                     rd_en,
    output logic [2*DATA_W-1:0]      rd_data,
    output logic                     rd_valid,
    output logic                     frame_ready,
    input  logic                     frame_ack,
    output logic                     seq_err,
    output logic [OVF_W-1:0]         ovf_cnt
`ifdef FFT_CAP_PEAK_EN
    ,
    output logic [CNT_W-1:0]         peak_bin,
    output logic [DATA_W:0]          peak_mag
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BINS - 1);

    cap_state_t         state_q, state_d;
    logic [CNT_W-1:0]   wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]   wr_addr;
    logic               wr_en;
    logic               bin_first;
    logic               swap;
    logic               drop;
    logic               wr_bank_q;      // read bank is always the other one
    logic               rd_sel_q;       // bank that produced the held rd_data
    logic               frame_ready_q;
    logic               seq_err_q;
    logic               rd_valid_q;
    logic [OVF_W-1:0]   ovf_q;
    logic [2*DATA_W-1:0] wdata;
    logic [2*DATA_W-1:0] rdata0, rdata1;

    assign wdata = {fft_real, fft_img};

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        wr_en     = 1'b0;
        wr_addr   = wr_idx_q;
        bin_first = 1'b0;
        swap      = 1'b0;
        drop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (fft_valid && fft_start) begin
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    bin_first = 1'b1;
                    wr_idx_d  = CNT_W'(1);
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (fft_valid) begin
                    wr_en = 1'b1;
                    if (fft_start) begin
                        // Restart: the partial frame is simply overwritten.
                        wr_addr   = '0;
                        bin_first = 1'b1;
                        wr_idx_d  = CNT_W'(1);
                    end else begin
                        wr_idx_d = wr_idx_q + CNT_W'(1);
                        if (wr_idx_q == LAST_IDX) begin
                            state_d = HANDOFF;
                        end
                    end
                end
            end
            HANDOFF: begin
                state_d = IDLE;
                if (!frame_ready_q || frame_ack) begin
                    swap = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= IDLE;
            wr_idx_q      <= '0;
            wr_bank_q     <= 1'b0;
            rd_sel_q      <= 1'b1;
            frame_ready_q <= 1'b0;
            seq_err_q     <= 1'b0;
            rd_valid_q    <= 1'b0;
            ovf_q         <= '0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_sel_q <= ~wr_bank_q;
            end
            // Start bins are expected to carry index 0.
            if (wr_en && (fft_cnt != wr_addr)) begin
                seq_err_q <= 1'b1;
            end
            // A swap wins over a same-cycle ack: the new bank is now the ready one.
            if (swap) begin
                wr_bank_q     <= ~wr_bank_q;
                frame_ready_q <= 1'b1;
            end else if (frame_ack) begin
                frame_ready_q <= 1'b0;
            end
            if (drop && (ovf_q != {OVF_W{1'b1}})) begin
                ovf_q <= ovf_q + OVF_W'(1);
            end
        end
    end

    fft_cap_bank_ram #(.WIDTH(2*DATA_W), .DEPTH(N_BINS)) u_bank0 (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .we    (wr_en && !wr_bank_q),
        .waddr (wr_addr),
        .wdata (wdata),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    fft_cap_bank_ram #(.WIDTH(2*DATA_W), .DEPTH(N_BINS)) u_bank1 (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .we    (wr_en && wr_bank_q),
        .waddr (wr_addr),
        .wdata (wdata),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    assign rd_data     = rd_sel_q ? rdata1 : rdata0;
    assign rd_valid    = rd_valid_q;
    assign frame_ready = frame_ready_q;
    assign seq_err     = seq_err_q;
    assign ovf_cnt     = ovf_q;

`ifdef FFT_CAP_PEAK_EN
    logic [DATA_W:0]  bin_mag;
    logic [DATA_W:0]  run_mag_q, peak_mag_q;
    logic [CNT_W-1:0] run_bin_q, peak_bin_q;

    assign bin_mag = (DATA_W+1)'(cap_mag(MAG_CALC_W'(fft_real), MAG_CALC_W'(fft_img)));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            run_mag_q  <= '0;
            run_bin_q  <= '0;
            peak_mag_q <= '0;
            peak_bin_q <= '0;
        end else begin
            // Strict compare keeps the lowest bin on ties.
            if (wr_en && (bin_first || (bin_mag > run_mag_q))) begin
                run_mag_q <= bin_mag;
                run_bin_q <= wr_addr;
            end
            if (swap) begin
                peak_mag_q <= run_mag_q;
                peak_bin_q <= run_bin_q;
            end
        end
    end

    assign peak_bin = peak_bin_q;
    assign peak_mag = peak_mag_q;
`endif

endmodule

// File: tb/tb_fft_frame_capture.sv
// tb/tb_fft_frame_capture.sv - self-checking bench for fft_frame_capture
module tb_fft_frame_capture;

    localparam int DATA_W = 24;
    localparam int N_BINS = 1024;
    localparam int OVF_W  = 8;
    localparam int CNT_W  = 10;

    logic                     clk_clk = 1'b0;
    logic                     reset_reset_n = 1'b0;
    logic                     fft_start = 1'b0;
    logic                     fft_valid = 1'b0;
    logic signed [DATA_W-1:0] fft_real = '0;
    logic signed [DATA_W-1:0] fft_img = '0;
    logic [CNT_W-1:0]         fft_cnt = '0;
    logic [CNT_W-1:0]         rd_addr = '0;
    logic                     rd_en = 1'b0;
    logic [2*DATA_W-1:0]      rd_data;
    logic                     rd_valid;
    logic                     frame_ready;
    logic                     frame_ack = 1'b0;
    logic                     seq_err;
    logic [OVF_W-1:0]         ovf_cnt;
`ifdef FFT_CAP_PEAK_EN
    logic [CNT_W-1:0]         peak_bin;
    logic [DATA_W:0]          peak_mag;
`endif

    fft_frame_capture #(.DATA_W(DATA_W), .N_BINS(N_BINS), .OVF_W(OVF_W)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .fft_start     (fft_start),
        .fft_valid     (fft_valid),
        .fft_real      (fft_real),
        .fft_img       (fft_img),
        .fft_cnt       (fft_cnt),
        .rd_addr       (rd_addr),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .frame_ready   (frame_ready),
        .frame_ack     (frame_ack),
        .seq_err       (seq_err),
        .ovf_cnt       (ovf_cnt)
`ifdef FFT_CAP_PEAK_EN
        ,
        .peak_bin      (peak_bin),
        .peak_mag      (peak_mag)
`endif
    );

    always #5 clk_clk = ~clk_clk;

    int checks   = 0;
    int failures = 0;

    // Model state: the frame being sent, the frame the CPU should see, handshake counters.
    logic [2*DATA_W-1:0] cur       [N_BINS];
    logic [2*DATA_W-1:0] exp_frame [N_BINS];
    bit     exp_ready    = 0;
    int     exp_ovf      = 0;
    int     exp_peak_bin = 0;
    longint exp_peak_mag = 0;

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic longint mag_of(input logic [2*DATA_W-1:0] w);
        longint re;
        longint im;
        re = longint'($signed(w[2*DATA_W-1:DATA_W]));
        im = longint'($signed(w[DATA_W-1:0]));
        return (re < 0 ? -re : re) + (im < 0 ? -im : im);
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < N_BINS; i++) begin
            if (mode == 0)      cur[i] = {DATA_W'(i), DATA_W'(-i)};
            else if (mode == 1) cur[i] = {DATA_W'($urandom()), DATA_W'($urandom())};
            else                cur[i] = '0;
        end
    endtask

    // Sends bins 0..n-1 of cur back to back; bin bad_idx carries bad_cnt as its index.
    task automatic send_bins(input int n, input int bad_idx, input int bad_cnt);
        for (int i = 0; i < n; i++) begin
            fft_valid = 1'b1;
            fft_start = (i == 0);
            fft_cnt   = CNT_W'((i == bad_idx) ? bad_cnt : i);
            fft_real  = cur[i][2*DATA_W-1:DATA_W];
            fft_img   = cur[i][DATA_W-1:0];
            step();
        end
        fft_valid = 1'b0;
        fft_start = 1'b0;
    endtask

    // Called right after the last bin: checks frame_ready has not risen yet, runs the
    // handoff cycle with an optional ack, and applies the hand-over rules to the model.
    task automatic finish_frame(input bit ack);
        longint best;
        chk("ready_before_handoff", 64'(frame_ready), 64'(exp_ready));
        frame_ack = ack;
        step();
        frame_ack = 1'b0;
        if (!exp_ready || ack) begin
            exp_frame = cur;
            exp_ready = 1;
            best = -1;
            for (int i = 0; i < N_BINS; i++) begin
                if (mag_of(cur[i]) > best) begin
                    best = mag_of(cur[i]);
                    exp_peak_bin = i;
                end
            end
            exp_peak_mag = best;
        end else if (exp_ovf < (1 << OVF_W) - 1) begin
            exp_ovf++;
        end
        chk("ready_after_handoff", 64'(frame_ready), 64'(exp_ready));
        chk("ovf_cnt", 64'(ovf_cnt), 64'(exp_ovf));
`ifdef FFT_CAP_PEAK_EN
        chk("peak_bin", 64'(peak_bin), 64'(exp_peak_bin));
        chk("peak_mag", 64'(peak_mag), 64'(exp_peak_mag));
`endif
    endtask

    task automatic read_chk(input int addr);
        rd_addr = CNT_W'(addr);
        rd_en   = 1'b1;
        step();
        rd_en   = 1'b0;
        chk("rd_valid", 64'(rd_valid), 64'd1);
        chk($sformatf("rd_data[%0d]", addr), 64'(rd_data), 64'(exp_frame[addr]));
    endtask

    task automatic read_random(input int n);
        for (int k = 0; k < n; k++) read_chk(int'($urandom_range(N_BINS - 1, 0)));
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        exp_ready = 0;
        chk("ready_after_ack", 64'(frame_ready), 64'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_frame_ready", 64'(frame_ready), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_seq_err", 64'(seq_err), 64'd0);
        chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
`ifdef FFT_CAP_PEAK_EN
        chk("rst_peak_bin", 64'(peak_bin), 64'd0);
        chk("rst_peak_mag", 64'(peak_mag), 64'd0);
`endif
    endtask

    initial begin
        logic [2*DATA_W-1:0] held;

        // Reset state
        step();
        step();
        chk_reset_outputs();
        reset_reset_n = 1'b1;
        step();

        // Ramp frame: real=i, img=-i; ready two cycles after the last bin
        fill(0);
        send_bins(N_BINS, -1, 0);
        finish_frame(1'b0);
        read_chk(5);
        chk("ramp_bin5_const", 64'(rd_data), 64'({24'd5, -24'sd5}));
        read_chk(0);
        read_chk(N_BINS - 1);
        held = rd_data;
        step();
        chk("rd_valid_drop", 64'(rd_valid), 64'd0);
        chk("rd_data_hold", 64'(rd_data), 64'(held));
        read_random(3);

        // Second frame without ack is dropped; ready bank keeps the ramp
        fill(1);
        send_bins(N_BINS, -1, 0);
        finish_frame(1'b0);
        read_chk(5);
        read_random(3);

        // After ack the next frame is accepted
        ack();
        fill(1);
        send_bins(N_BINS, -1, 0);
        finish_frame(1'b0);
        read_random(4);

        // Ack in the handoff cycle: ready stays high and holds the new frame
        fill(1);
        send_bins(N_BINS, -1, 0);
        finish_frame(1'b1);
        read_random(4);

        // Restart at bin 300: partial frame discarded, no overflow counted
        ack();
        fill(1);
        send_bins(300, -1, 0);
        fill(1);
        send_bins(N_BINS, -1, 0);
        finish_frame(1'b0);
        read_chk(0);
        read_chk(299);
        read_chk(300);
        read_chk(N_BINS - 1);

        // Sequence error: index 7 presented where 6 was expected
        ack();
        chk("seq_err_clean", 64'(seq_err), 64'd0);
        fill(1);
        send_bins(N_BINS, 6, 7);
        chk("seq_err_set", 64'(seq_err), 64'd1);
        finish_frame(1'b0);
        read_chk(6);
        read_chk(7);

        // Ack while not ready is ignored; lone valids in IDLE are ignored
        ack();
        ack();
        for (int i = 0; i < 5; i++) begin
            fft_valid = 1'b1;
            fft_cnt   = CNT_W'(i);
            fft_real  = DATA_W'($urandom());
            fft_img   = DATA_W'($urandom());
            step();
        end
        fft_valid = 1'b0;
        fill(1);
        send_bins(N_BINS, -1, 0);
        finish_frame(1'b0);
        chk("seq_err_sticky", 64'(seq_err), 64'd1);
        read_random(4);

`ifdef FFT_CAP_PEAK_EN
        // Two equal most-negative peaks: the lower bin wins
        ack();
        fill(2);
        cur[40] = {24'h800000, 24'h000000};
        cur[90] = {24'h800000, 24'h000000};
        send_bins(N_BINS, -1, 0);
        finish_frame(1'b0);
        chk("peak_bin_tie", 64'(peak_bin), 64'd40);
        chk("peak_mag_tie", 64'(peak_mag), 64'd8388608);
`endif

        // Reset mid-frame aborts the capture and clears all outputs
        ack();
        fill(1);
        send_bins(500, -1, 0);
        reset_reset_n = 1'b0;
        #1;
        chk_reset_outputs();
        exp_ready    = 0;
        exp_ovf      = 0;
        exp_peak_bin = 0;
        exp_peak_mag = 0;
        step();
        reset_reset_n = 1'b1;
        step();
        chk("ready_after_reset", 64'(frame_ready), 64'd0);
        fill(1);
        send_bins(N_BINS, -1, 0);
        finish_frame(1'b0);
        chk("seq_err_after_reset", 64'(seq_err), 64'd0);
        read_random(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
